// File: rtl/prog_pkg.sv
// Shared constants, FSM state type and the SECDED syndrome helper for prog_top.
package prog_pkg;

    localparam logic [7:0] ENC_IN_BASE  = 8'd0;
    localparam logic [7:0] ENC_OUT_BASE = 8'd30;
    localparam logic [7:0] DEC_IN_BASE  = 8'd64;
    localparam logic [7:0] DEC_OUT_BASE = 8'd94;
    localparam logic [7:0] STR_BASE     = 8'd128;
    localparam logic [7:0] PAT_ADDR     = 8'd160;
    localparam logic [7:0] CNT_A_ADDR   = 8'd192;
    localparam logic [7:0] CNT_B_ADDR   = 8'd193;
    localparam logic [7:0] CNT_C_ADDR   = 8'd194;

    localparam int WORD_CNT = 15;
    localparam int BYTE_CNT = 32;

    typedef enum logic [2:0] {IDLE, P1, P2, P3_SCAN, P3_WR, DONE} state_t;

    // Returns {overall parity, 4-bit syndrome}; the syndrome is the XOR of set bit positions.
    function automatic logic [4:0] syndrome(input logic [15:0] w);
        logic [3:0] s;
        s = '0;
        for (int k = 1; k < 16; k++) begin
            if (w[k]) s = s ^ 4'(k);
        end
        return {^w, s};
    endfunction

endpackage

// File: rtl/prog_dm.sv
// 256x8 data memory: two asynchronous read ports, one synchronous write port.
// Latency: reads combinational, writes land on the rising edge.
// Backpressure: none; the array is never cleared by reset.
module dm (
    input  logic       clk,
    input  logic [7:0] rd_addr_a,
    output logic [7:0] rd_dat_a,
    input  logic [7:0] rd_addr_b,
    output logic [7:0] rd_dat_b,
    input  logic       wr_en,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_dat
);

    logic [7:0] core [256];

    assign rd_dat_a = core[rd_addr_a];
    assign rd_dat_b = core[rd_addr_b];

    always_ff @(posedge clk) begin
        if (wr_en) core[wr_addr] <= wr_dat;
    end

endmodule

// File: rtl/prog_top.sv
// Fixed-function engine: runs SECDED encode, SECDED decode, pattern count in rotation per req.
// Latency: encode/decode 30 cycles, pattern count 35 cycles from the edge that samples req.
// Backpressure: req is ignored while a program runs; ack holds high until the next req.
module prog_top
    import prog_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req,
    output logic ack
);

    localparam logic [3:0] LAST_WORD = 4'(WORD_CNT - 1);
    localparam logic [4:0] LAST_BYTE = 5'(BYTE_CNT - 1);

    state_t     state;
    logic [1:0] prog_ptr;
    logic [3:0] idx;
    logic       half;
    logic [4:0] kb;
    logic [1:0] wr_step;
    logic [3:0] prev_nib;
    logic [7:0] cnt_a, cnt_b, cnt_c;

    logic [7:0] rd_addr_a, rd_addr_b, rd_dat_a, rd_dat_b;
    logic [7:0] wr_addr, wr_dat, off;
    logic       wr_en;

    logic [15:0] enc_raw, enc_w, dec_in, dec_o;
    logic [4:0]  syn_e, syn_d;
    logic [10:0] dec_d;
    logic [3:0]  pos;
    logic        dec_fix, dec_de;
    logic [11:0] win;
    logic [3:0]  n_int, n_cross;

    dm dm1 (
        .clk       (clk),
        .rd_addr_a (rd_addr_a),
        .rd_dat_a  (rd_dat_a),
        .rd_addr_b (rd_addr_b),
        .rd_dat_b  (rd_dat_b),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_dat    (wr_dat)
    );

    always_comb begin
        off       = {3'b000, idx, 1'b0};
        rd_addr_a = ENC_IN_BASE + off;
        rd_addr_b = ENC_IN_BASE + off + 8'd1;
        if (state == P2) begin
            rd_addr_a = DEC_IN_BASE + off;
            rd_addr_b = DEC_IN_BASE + off + 8'd1;
        end else if (state == P3_SCAN) begin
            rd_addr_a = STR_BASE + {3'b000, kb};
            rd_addr_b = PAT_ADDR;
        end
    end

    // Parity bits come from the syndrome of the data-only word, which zeroes it once inserted.
    assign enc_raw = {rd_dat_b[2:0], rd_dat_a[7:4], 1'b0, rd_dat_a[3:1], 1'b0, rd_dat_a[0], 3'b000};
    assign syn_e   = syndrome(enc_raw);
    assign enc_w   = enc_raw | {7'b0, syn_e[3], 3'b0, syn_e[2], 1'b0, syn_e[1], syn_e[0],
                                syn_e[4] ^ (^syn_e[3:0])};

    always_comb begin
        dec_in  = {rd_dat_b, rd_dat_a};
        syn_d   = syndrome(dec_in);
        dec_fix = syn_d[4] && (syn_d[3:0] != 4'd0);
        dec_de  = !syn_d[4] && (syn_d[3:0] != 4'd0);
        dec_d   = '0;
        pos     = '0;
        for (int i = 0; i < 11; i++) begin
            pos      = (i == 0) ? 4'd3 : (i < 4) ? 4'(i + 4) : 4'(i + 5);
            dec_d[i] = dec_in[pos] ^ (dec_fix && (syn_d[3:0] == pos));
        end
        dec_o = {dec_de, 4'b0000, dec_d};
    end

    // Byte 0 has no predecessor, so its byte-crossing windows are not counted.
    always_comb begin
        win     = {prev_nib, rd_dat_a};
        n_int   = '0;
        n_cross = '0;
        for (int j = 0; j < 4; j++) begin
            if (win[j +: 5] == rd_dat_b[7:3]) n_int = n_int + 4'd1;
        end
        for (int j = 4; j < 8; j++) begin
            if (kb != 5'd0 && win[j +: 5] == rd_dat_b[7:3]) n_cross = n_cross + 4'd1;
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_dat  = '0;
        case (state)
            P1: begin
                wr_en   = 1'b1;
                wr_addr = ENC_OUT_BASE + off + {7'b0, half};
                wr_dat  = half ? enc_w[15:8] : enc_w[7:0];
            end
            P2: begin
                wr_en   = 1'b1;
                wr_addr = DEC_OUT_BASE + off + {7'b0, half};
                wr_dat  = half ? dec_o[15:8] : dec_o[7:0];
            end
            P3_WR: begin
                wr_en = 1'b1;
                case (wr_step)
                    2'd0:    begin wr_addr = CNT_A_ADDR; wr_dat = cnt_a; end
                    2'd1:    begin wr_addr = CNT_B_ADDR; wr_dat = cnt_b; end
                    default: begin wr_addr = CNT_C_ADDR; wr_dat = cnt_c; end
                endcase
            end
            default: ;
        endcase
        // Reset aborts the program before the write that would share its edge.
        if (reset) wr_en = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            prog_ptr <= 2'd1;
            ack      <= 1'b0;
            idx      <= '0;
            half     <= 1'b0;
            kb       <= '0;
            wr_step  <= '0;
            prev_nib <= '0;
            cnt_a    <= '0;
            cnt_b    <= '0;
            cnt_c    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (req) begin
                        ack      <= 1'b0;
                        idx      <= '0;
                        half     <= 1'b0;
                        kb       <= '0;
                        wr_step  <= '0;
                        prev_nib <= '0;
                        cnt_a    <= '0;
                        cnt_b    <= '0;
                        cnt_c    <= '0;
                        case (prog_ptr)
                            2'd1:    state <= P1;
                            2'd2:    state <= P2;
                            default: state <= P3_SCAN;
                        endcase
                    end
                end
                P1, P2: begin
                    half <= ~half;
                    if (half) begin
                        idx <= idx + 4'd1;
                        if (idx == LAST_WORD) begin
                            state    <= DONE;
                            ack      <= 1'b1;
                            prog_ptr <= (state == P1) ? 2'd2 : 2'd3;
                        end
                    end
                end
                P3_SCAN: begin
                    cnt_a    <= cnt_a + {4'b0000, n_int};
                    cnt_b    <= cnt_b + {7'b0, n_int != 4'd0};
                    cnt_c    <= cnt_c + {4'b0000, n_int + n_cross};
                    prev_nib <= rd_dat_a[3:0];
                    kb       <= kb + 5'd1;
                    if (kb == LAST_BYTE) state <= P3_WR;
                end
                P3_WR: begin
                    wr_step <= wr_step + 2'd1;
                    if (wr_step == 2'd2) begin
                        state    <= DONE;
                        ack      <= 1'b1;
                        prog_ptr <= 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_top.sv
// Randomized bench for prog_top with a behavioural memory model and directed corner cases.
module tb_prog_top;

    logic clk = 1'b0;
    logic reset;
    logic req;
    logic ack;

    prog_top dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .ack   (ack)
    );

    always #5 clk = ~clk;

    logic [7:0] m [256];
    int n_checks = 0;
    int n_err    = 0;
    int tb_ptr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task mem_wr(input int a, input logic [7:0] v);
        dut.dm1.core[a] <= v;
        m[a] = v;
    endtask

    function automatic logic [15:0] ref_enc(input logic [11:1] d);
        logic p8, p4, p2, p1, p0;
        p8 = ^d[11:5];
        p4 = (^d[11:8]) ^ (^d[4:2]);
        p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
        p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
        p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
        return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
    endfunction

    function automatic logic [15:0] ref_dec(input logic [15:0] w_in);
        logic [15:0] w;
        logic [3:0]  s;
        logic        de;
        w  = w_in;
        s  = 4'd0;
        de = 1'b0;
        for (int k = 1; k < 16; k++) if (w[k]) s = s ^ 4'(k);
        if (^w) begin
            if (s != 4'd0) w[s] = ~w[s];
        end else if (s != 4'd0) begin
            de = 1'b1;
        end
        return {de, 4'b0000, w[15:9], w[7:5], w[3]};
    endfunction

    task automatic compare_mem();
        for (int i = 0; i < 256; i++)
            chk($sformatf("mem[%0d]", i), dut.dm1.core[i], m[i]);
    endtask

    task automatic setup_p1(input int r);
        logic [10:0] d;
        logic [4:0]  up;
        for (int i = 0; i < 15; i++) begin
            d  = 11'($urandom);
            up = 5'($urandom);
            if (r == 0 && i == 0) d = 11'h000;
            if (r == 0 && i == 1) d = 11'h001;
            if (r == 0 && i == 2) d = 11'h7FF;
            mem_wr(2 * i, d[7:0]);
            mem_wr(2 * i + 1, {up, d[10:8]});
        end
    endtask

    task automatic model_p1();
        logic [15:0] w;
        for (int i = 0; i < 15; i++) begin
            w = ref_enc({m[2 * i + 1][2:0], m[2 * i]});
            m[30 + 2 * i] = w[7:0];
            m[31 + 2 * i] = w[15:8];
        end
    endtask

    task automatic setup_p2(input int r);
        logic [15:0] w;
        int b1, b2;
        for (int i = 0; i < 15; i++) begin
            w  = ref_enc(11'($urandom));
            b1 = $urandom_range(0, 15);
            b2 = (b1 + $urandom_range(1, 15)) % 16;
            case ($urandom_range(0, 3))
                1:       w[b1] = ~w[b1];
                2:       begin w[b1] = ~w[b1]; w[b2] = ~w[b2]; end
                3:       w = 16'($urandom);
                default: ;
            endcase
            if (r == 0 && i == 0) w = 16'h000C;
            if (r == 0 && i == 1) w = 16'h020F;
            if (r == 0 && i == 2) w = 16'h000E;
            mem_wr(64 + 2 * i, w[7:0]);
            mem_wr(65 + 2 * i, w[15:8]);
        end
    endtask

    task automatic model_p2(input int n_bytes);
        logic [15:0] o;
        for (int i = 0; i < 15; i++) begin
            o = ref_dec({m[65 + 2 * i], m[64 + 2 * i]});
            if (2 * i < n_bytes)     m[94 + 2 * i] = o[7:0];
            if (2 * i + 1 < n_bytes) m[95 + 2 * i] = o[15:8];
        end
    endtask

    task automatic setup_p3(input int r);
        logic [4:0] pat;
        logic [7:0] v;
        pat = 5'($urandom);
        if (r == 0) mem_wr(160, 8'h00);
        else if (r == 1) mem_wr(160, {5'b10101, 3'($urandom)});
        else mem_wr(160, {pat, 3'($urandom)});
        for (int b = 0; b < 32; b++) begin
            case ($urandom_range(0, 5))
                0:       v = 8'h00;
                1:       v = 8'hFF;
                2:       v = 8'h55;
                3:       v = {pat, 3'($urandom)};
                4:       v = {3'($urandom), pat};
                default: v = 8'($urandom);
            endcase
            if (r == 0) v = 8'h00;
            if (r == 1) v = 8'h55;
            mem_wr(128 + b, v);
        end
    endtask

    task automatic model_p3();
        logic [255:0] str;
        logic [7:0]   bv;
        logic [4:0]   pat;
        int ca, cb, cc;
        bit hit;
        pat = m[160][7:3];
        ca = 0; cb = 0; cc = 0;
        for (int b = 0; b < 32; b++) begin
            bv  = m[128 + b];
            str[255 - 8 * b -: 8] = bv;
            hit = 1'b0;
            for (int s = 0; s < 4; s++) begin
                if (bv[s +: 5] == pat) begin ca++; hit = 1'b1; end
            end
            if (hit) cb++;
        end
        for (int p = 0; p < 252; p++) if (str[p +: 5] == pat) cc++;
        m[192] = 8'(ca);
        m[193] = 8'(cb);
        m[194] = 8'(cc);
    endtask

    task automatic start_req();
        @(negedge clk);
        req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        chk("ack_fall", ack, 1'b0);
    endtask

    task automatic wait_ack(input int exp_cyc, input bit poke);
        int n;
        for (n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1 req = 1'b0;
            if (ack) break;
            if (poke && n == 10) req = 1'b1;
        end
        chk("done_cycles", n, exp_cyc);
    endtask

    task automatic do_prog(input int r, input bit poke);
        case (tb_ptr)
            1:       setup_p1(r);
            2:       setup_p2(r);
            default: setup_p3(r);
        endcase
        start_req();
        wait_ack((tb_ptr == 3) ? 35 : 30, poke);
        case (tb_ptr)
            1:       model_p1();
            2:       model_p2(30);
            default: model_p3();
        endcase
        compare_mem();
        if (r == 0 && tb_ptr == 1) begin
            chk("enc_d000", {dut.dm1.core[31], dut.dm1.core[30]}, 16'h0000);
            chk("enc_d001", {dut.dm1.core[33], dut.dm1.core[32]}, 16'h000F);
            chk("enc_d7ff", {dut.dm1.core[35], dut.dm1.core[34]}, 16'hFFFF);
        end
        if (r == 0 && tb_ptr == 2) begin
            chk("dec_double_de", dut.dm1.core[95][7], 1'b1);
            chk("dec_flip9", {dut.dm1.core[97], dut.dm1.core[96]}, 16'h0001);
            chk("dec_flip_p0", {dut.dm1.core[99], dut.dm1.core[98]}, 16'h0001);
        end
        if (r <= 1 && tb_ptr == 3) begin
            chk("pat_cnt_a", dut.dm1.core[192], (r == 0) ? 128 : 64);
            chk("pat_cnt_b", dut.dm1.core[193], 32);
            chk("pat_cnt_c", dut.dm1.core[194], (r == 0) ? 252 : 126);
        end
        repeat (2) @(posedge clk);
        #1 chk("ack_hold", ack, 1'b1);
        tb_ptr = (tb_ptr == 3) ? 1 : tb_ptr + 1;
    endtask

    initial begin
        reset = 1'b1;
        req   = 1'b0;
        for (int i = 0; i < 256; i++) mem_wr(i, 8'($urandom));
        repeat (3) @(posedge clk);
        #1 chk("reset_ack", ack, 1'b0);
        @(negedge clk);
        reset  = 1'b0;
        tb_ptr = 1;

        // Three full rotations; the fourth req reruns encode, round 2 pokes req mid-encode.
        for (int r = 0; r < 3; r++)
            for (int p = 0; p < 3; p++)
                do_prog(r, r == 2 && p == 0);

        // Abort decode after seven byte writes; the next req must run encode again.
        do_prog(3, 1'b0);
        setup_p2(3);
        start_req();
        repeat (7) @(posedge clk);
        model_p2(7);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 chk("abort_ack", ack, 1'b0);
        @(negedge clk);
        reset  = 1'b0;
        compare_mem();
        tb_ptr = 1;

        for (int p = 0; p < 3; p++) do_prog(4, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
